// File: rtl/exc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// ExcRedirectCtrl -- exception / ERET redirect sequencer
//
// Turns the M-stage exception decision into a clean pipeline redirect:
// it commits the CP0 exception (or ERET) update in the take cycle, flushes
// the pipeline, drains any outstanding instruction-bus requests so stale
// fetch data is never consumed, then offers a single handshaked PC redirect
// to the fetch stage.
//
// Ports
//   clk, resetn            core clock, asynchronous active-low reset
//   valid_m_i              M stage holds a real instruction
//   excepttype_m_i         exception type (0 none, 1/4/5/8/9/a/c, e = ERET)
//   newpc_m_i              redirect target (handler vector or EPC)
//   pc_m_i                 PC of the M-stage instruction
//   in_delayslot_m_i       M-stage instruction sits in a branch delay slot
//   badvaddr_m_i           faulting address for AdEL/AdES
//   inst_req_i             fetch raises an instruction-bus request
//   inst_addr_ok_i         request accepted by the bus
//   inst_data_ok_i         data returned by the bus
//   redirect_ready_i       fetch accepts the redirect
//   cp0_exc_we_o           one-cycle CP0 exception write pulse
//   cp0_exccode_o          Cause.ExcCode for the write
//   cp0_epc_o, cp0_bd_o    EPC value and Cause.BD
//   cp0_badvaddr_o         BadVAddr value
//   cp0_badvaddr_we_o      qualifies the BadVAddr write
//   eret_o                 one-cycle pulse clearing Status.EXL
//   flush_o                flush all pipeline stages
//   stall_o                freeze PC and pipeline registers
//   discard_fetch_o        drop returning instruction-bus data
//   inst_req_block_o       fetch must not raise a new request
//   redirect_valid_o       redirect request (registered)
//   redirect_pc_o          redirect target (registered)
// ---------------------------------------------------------------------------
module exc_redirect_ctrl #(
    parameter int          MAX_OUT    = 3,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_m_i,
    input  logic [31:0] excepttype_m_i,
    input  logic [31:0] newpc_m_i,
    input  logic [31:0] pc_m_i,
    input  logic        in_delayslot_m_i,
    input  logic [31:0] badvaddr_m_i,
    input  logic        inst_req_i,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic        redirect_ready_i,
    output logic        cp0_exc_we_o,
    output logic [4:0]  cp0_exccode_o,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_bd_o,
    output logic [31:0] cp0_badvaddr_o,
    output logic        cp0_badvaddr_we_o,
    output logic        eret_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        discard_fetch_o,
    output logic        inst_req_block_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    localparam int               CNT_W   = (MAX_OUT < 2) ? 1 : $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    localparam logic [31:0] TYPE_INT  = 32'h1;
    localparam logic [31:0] TYPE_ADEL = 32'h4;
    localparam logic [31:0] TYPE_ADES = 32'h5;
    localparam logic [31:0] TYPE_SYS  = 32'h8;
    localparam logic [31:0] TYPE_BP   = 32'h9;
    localparam logic [31:0] TYPE_RI   = 32'ha;
    localparam logic [31:0] TYPE_OV   = 32'hc;
    localparam logic [31:0] TYPE_ERET = 32'he;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_next;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic [31:0]       target_q;
    logic [31:0]       redirect_pc_q;

    logic              take;
    logic              is_eret;
    logic              exc_commit;
    logic              eret_commit;
    logic              is_addr_err;
    logic              bus_inc;
    logic              bus_dec;
    logic              enter_redir;
    logic              leave_redir;

    // Unknown exception types fall back to the Reserved Instruction code so
    // CP0 always receives a legal ExcCode.
    function automatic logic [4:0] map_exccode(input logic [31:0] etype);
        logic [4:0] code;
        case (etype)
            TYPE_INT:  code = 5'h00;
            TYPE_ADEL: code = 5'h04;
            TYPE_ADES: code = 5'h05;
            TYPE_SYS:  code = 5'h08;
            TYPE_BP:   code = 5'h09;
            TYPE_RI:   code = 5'h0a;
            TYPE_OV:   code = 5'h0c;
            default:   code = 5'h0a;
        endcase
        return code;
    endfunction

    // Take decode. Gating with resetn keeps every combinational commit output
    // at zero while reset is held, even if M stage still presents an exception.
    always_comb begin
        take        = resetn && (state_q == ST_IDLE) && valid_m_i
                      && (excepttype_m_i != 32'h0);
        is_eret     = (excepttype_m_i == TYPE_ERET);
        exc_commit  = take && !is_eret;
        eret_commit = take && is_eret;
        is_addr_err = (excepttype_m_i == TYPE_ADEL) || (excepttype_m_i == TYPE_ADES);
    end

    // Outstanding instruction-bus request counter. A simultaneous accept and
    // return cancel out; a return with nothing outstanding is ignored, and the
    // count saturates at MAX_OUT rather than wrapping.
    always_comb begin
        bus_inc    = inst_req_i && inst_addr_ok_i;
        bus_dec    = inst_data_ok_i;
        count_next = count_q;
        if (bus_inc && !bus_dec) begin
            if (count_q != CNT_MAX) begin
                count_next = count_q + 1'b1;
            end
        end else if (!bus_inc && bus_dec) begin
            if (count_q != '0) begin
                count_next = count_q - 1'b1;
            end
        end
    end

    // Next-state logic. Both IDLE and DRAIN look at the count that will be
    // registered at this edge, so the redirect appears in the cycle right
    // after the last data return.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_next = (count_next != '0) ? ST_DRAIN : ST_REDIR;
                end
            end
            ST_DRAIN: begin
                if (count_next == '0) begin
                    state_next = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (redirect_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        enter_redir = (state_q != ST_REDIR) && (state_next == ST_REDIR);
        leave_redir = (state_q == ST_REDIR) && (state_next != ST_REDIR);
    end

    // State, counter and target registers. The counter runs in every state so
    // requests accepted during the sequence are still tracked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_next;
            count_q <= count_next;
        end
    end

    // The target is captured in the take cycle; when the FSM skips DRAIN the
    // redirect register is loaded straight from the M-stage value because the
    // latched copy is not yet visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            target_q      <= 32'h0;
            redirect_pc_q <= 32'h0;
        end else begin
            if (take) begin
                target_q <= newpc_m_i;
            end
            if (enter_redir) begin
                redirect_pc_q <= (state_q == ST_IDLE) ? newpc_m_i : target_q;
            end else if (leave_redir) begin
                redirect_pc_q <= 32'h0;
            end
        end
    end

    // Commit data and pipeline control. CP0 data fields are driven only while
    // their write strobe is high so CP0 never sees stale values.
    always_comb begin
        cp0_exc_we_o      = 1'b0;
        cp0_exccode_o     = 5'h00;
        cp0_epc_o         = 32'h0;
        cp0_bd_o          = 1'b0;
        cp0_badvaddr_o    = 32'h0;
        cp0_badvaddr_we_o = 1'b0;
        eret_o            = 1'b0;

        if (exc_commit) begin
            cp0_exc_we_o  = 1'b1;
            cp0_exccode_o = map_exccode(excepttype_m_i);
            cp0_epc_o     = in_delayslot_m_i ? (pc_m_i - 32'd4) : pc_m_i;
            cp0_bd_o      = in_delayslot_m_i;
            if (is_addr_err) begin
                cp0_badvaddr_we_o = 1'b1;
                cp0_badvaddr_o    = badvaddr_m_i;
            end
        end
        if (eret_commit) begin
            eret_o = 1'b1;
        end

        flush_o          = take || (state_q == ST_DRAIN) || (state_q == ST_REDIR);
        discard_fetch_o  = take || (state_q == ST_DRAIN) || (state_q == ST_REDIR);
        stall_o          = (state_q == ST_DRAIN);
        inst_req_block_o = (count_q == CNT_MAX) || (state_q == ST_DRAIN);
    end

    assign redirect_valid_o = (state_q == ST_REDIR);
    assign redirect_pc_o    = redirect_pc_q;

    // A real exception must always vector to the handler entry point.
    a_exc_vector: assert property (
        @(posedge clk) disable iff (!resetn)
        exc_commit |-> (newpc_m_i == EXC_VECTOR)
    );

    // The redirect offer must hold steady until fetch takes it.
    a_redirect_stable: assert property (
        @(posedge clk) disable iff (!resetn)
        (redirect_valid_o && !redirect_ready_i) |=> (redirect_valid_o && $stable(redirect_pc_o))
    );

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// TbExcRedirectCtrl -- self-checking bench for exc_redirect_ctrl
//
// Table of commit vectors applied in a loop, followed by hand-written
// sequences for redirect timing, bus draining, counter limits and an
// asynchronous reset in the middle of a drain. Expected redirect targets are
// queued when an exception is driven and compared when fetch accepts them.
// ---------------------------------------------------------------------------
module tb_exc_redirect_ctrl;

    logic        clk;
    logic        resetn;
    logic        valid_m_i;
    logic [31:0] excepttype_m_i;
    logic [31:0] newpc_m_i;
    logic [31:0] pc_m_i;
    logic        in_delayslot_m_i;
    logic [31:0] badvaddr_m_i;
    logic        inst_req_i;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic        redirect_ready_i;
    logic        cp0_exc_we_o;
    logic [4:0]  cp0_exccode_o;
    logic [31:0] cp0_epc_o;
    logic        cp0_bd_o;
    logic [31:0] cp0_badvaddr_o;
    logic        cp0_badvaddr_we_o;
    logic        eret_o;
    logic        flush_o;
    logic        stall_o;
    logic        discard_fetch_o;
    logic        inst_req_block_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int          checkCount;
    int          errorCount;
    logic [31:0] sbQueue[$];

    localparam logic [31:0] VEC = 32'hbfc00380;

    typedef struct packed {
        logic        valid;
        logic [31:0] etype;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic [31:0] newpc;
        logic        take;
        logic        checkData;
        logic        excWe;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        bvWe;
        logic [31:0] bv;
    } vec_t;

    vec_t vecs[11];

    exc_redirect_ctrl #(
        .MAX_OUT    (3),
        .EXC_VECTOR (32'hbfc00380)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .valid_m_i         (valid_m_i),
        .excepttype_m_i    (excepttype_m_i),
        .newpc_m_i         (newpc_m_i),
        .pc_m_i            (pc_m_i),
        .in_delayslot_m_i  (in_delayslot_m_i),
        .badvaddr_m_i      (badvaddr_m_i),
        .inst_req_i        (inst_req_i),
        .inst_addr_ok_i    (inst_addr_ok_i),
        .inst_data_ok_i    (inst_data_ok_i),
        .redirect_ready_i  (redirect_ready_i),
        .cp0_exc_we_o      (cp0_exc_we_o),
        .cp0_exccode_o     (cp0_exccode_o),
        .cp0_epc_o         (cp0_epc_o),
        .cp0_bd_o          (cp0_bd_o),
        .cp0_badvaddr_o    (cp0_badvaddr_o),
        .cp0_badvaddr_we_o (cp0_badvaddr_we_o),
        .eret_o            (eret_o),
        .flush_o           (flush_o),
        .stall_o           (stall_o),
        .discard_fetch_o   (discard_fetch_o),
        .inst_req_block_o  (inst_req_block_o),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_pc_o     (redirect_pc_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] etype,
                                 input logic [31:0] pc, input logic ds,
                                 input logic [31:0] badv, input logic [31:0] npc);
        valid_m_i        = v;
        excepttype_m_i   = etype;
        pc_m_i           = pc;
        in_delayslot_m_i = ds;
        badvaddr_m_i     = badv;
        newpc_m_i        = npc;
    endtask

    task automatic clearM();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic busCycle(input logic req, input logic dok);
        nextCycle();
        inst_req_i     = req;
        inst_addr_ok_i = req;
        inst_data_ok_i = dok;
    endtask

    task automatic checkBlock(input string name, input logic expected);
        busCycle(1'b0, 1'b0);
        @(negedge clk);
        checkOutput(name, inst_req_block_o, expected);
    endtask

    // Scoreboard: every accepted redirect must match the oldest queued target.
    always @(negedge clk) begin
        if (resetn && redirect_valid_o && redirect_ready_i) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpected_redirect", 32'h1, 32'h0);
            end else begin
                checkOutput("sb_redirect_pc", redirect_pc_o, sbQueue.pop_front());
            end
        end
    end

    initial begin
        checkCount = 0;
        errorCount = 0;

        //            valid etype   pc            ds    badv          newpc          take chk  we   eret code   epc           bd   bvwe bv
        vecs[0]  = '{1'b1, 32'h8, 32'hbfc00100, 1'b0, 32'h0,        VEC,           1'b1,1'b1,1'b1,1'b0,5'h08,32'hbfc00100,1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b1, 32'h4, 32'h80000010, 1'b1, 32'h80000003, VEC,           1'b1,1'b1,1'b1,1'b0,5'h04,32'h8000000c,1'b1,1'b1,32'h80000003};
        vecs[2]  = '{1'b1, 32'h5, 32'h80001000, 1'b0, 32'h80001002, VEC,           1'b1,1'b1,1'b1,1'b0,5'h05,32'h80001000,1'b0,1'b1,32'h80001002};
        vecs[3]  = '{1'b1, 32'h1, 32'h80000200, 1'b1, 32'h0,        VEC,           1'b1,1'b1,1'b1,1'b0,5'h00,32'h800001fc,1'b1,1'b0,32'h0};
        vecs[4]  = '{1'b1, 32'h9, 32'h80000400, 1'b0, 32'h12345678, VEC,           1'b1,1'b1,1'b1,1'b0,5'h09,32'h80000400,1'b0,1'b0,32'h0};
        vecs[5]  = '{1'b1, 32'ha, 32'h80000500, 1'b0, 32'h0,        VEC,           1'b1,1'b1,1'b1,1'b0,5'h0a,32'h80000500,1'b0,1'b0,32'h0};
        vecs[6]  = '{1'b1, 32'hc, 32'h80000004, 1'b1, 32'h0,        VEC,           1'b1,1'b1,1'b1,1'b0,5'h0c,32'h80000000,1'b1,1'b0,32'h0};
        vecs[7]  = '{1'b1, 32'he, 32'h80000300, 1'b0, 32'h0,        32'hbfc00200,  1'b1,1'b0,1'b0,1'b1,5'h00,32'h0,       1'b0,1'b0,32'h0};
        vecs[8]  = '{1'b1, 32'h3, 32'h80000600, 1'b0, 32'h0,        VEC,           1'b1,1'b1,1'b1,1'b0,5'h0a,32'h80000600,1'b0,1'b0,32'h0};
        vecs[9]  = '{1'b0, 32'h8, 32'h80000700, 1'b0, 32'h0,        VEC,           1'b0,1'b0,1'b0,1'b0,5'h00,32'h0,       1'b0,1'b0,32'h0};
        vecs[10] = '{1'b1, 32'h0, 32'h80000800, 1'b0, 32'h0,        VEC,           1'b0,1'b0,1'b0,1'b0,5'h00,32'h0,       1'b0,1'b0,32'h0};

        resetn           = 1'b0;
        clearM();
        inst_req_i       = 1'b0;
        inst_addr_ok_i   = 1'b0;
        inst_data_ok_i   = 1'b0;
        redirect_ready_i = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_flush", flush_o, 1'b0);
        checkOutput("rst_stall", stall_o, 1'b0);
        checkOutput("rst_block", inst_req_block_o, 1'b0);
        checkOutput("rst_redirect_valid", redirect_valid_o, 1'b0);
        checkOutput("rst_redirect_pc", redirect_pc_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Table-driven commit vectors, each followed by an immediate redirect
        for (int i = 0; i < 11; i++) begin
            nextCycle();
            applyStimulus(vecs[i].valid, vecs[i].etype, vecs[i].pc, vecs[i].ds,
                          vecs[i].badv, vecs[i].newpc);
            if (vecs[i].take) sbQueue.push_back(vecs[i].newpc);
            @(negedge clk);
            checkOutput($sformatf("v%0d_exc_we", i), cp0_exc_we_o, vecs[i].excWe);
            checkOutput($sformatf("v%0d_eret", i), eret_o, vecs[i].eret);
            checkOutput($sformatf("v%0d_flush", i), flush_o, vecs[i].take);
            checkOutput($sformatf("v%0d_discard", i), discard_fetch_o, vecs[i].take);
            if (vecs[i].checkData) begin
                checkOutput($sformatf("v%0d_exccode", i), cp0_exccode_o, vecs[i].code);
                checkOutput($sformatf("v%0d_epc", i), cp0_epc_o, vecs[i].epc);
                checkOutput($sformatf("v%0d_bd", i), cp0_bd_o, vecs[i].bd);
                checkOutput($sformatf("v%0d_badv_we", i), cp0_badvaddr_we_o, vecs[i].bvWe);
                checkOutput($sformatf("v%0d_badv", i), cp0_badvaddr_o, vecs[i].bv);
            end
            nextCycle();
            clearM();
            redirect_ready_i = vecs[i].take;
            @(negedge clk);
            checkOutput($sformatf("v%0d_redirect_valid", i), redirect_valid_o, vecs[i].take);
            nextCycle();
            redirect_ready_i = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("v%0d_redirect_done", i), redirect_valid_o, 1'b0);
        end

        // Syscall timing: redirect from T+1, accepted at T+3, second exception ignored
        nextCycle();
        applyStimulus(1'b1, 32'h8, 32'hbfc00100, 1'b0, 32'h0, VEC);
        sbQueue.push_back(VEC);
        @(negedge clk);
        checkOutput("sys_we_T", cp0_exc_we_o, 1'b1);
        checkOutput("sys_rv_T", redirect_valid_o, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("sys_we_T1", cp0_exc_we_o, 1'b0);
        checkOutput("sys_rv_T1", redirect_valid_o, 1'b1);
        checkOutput("sys_rpc_T1", redirect_pc_o, VEC);
        checkOutput("sys_stall_T1", stall_o, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h4, 32'h80000010, 1'b0, 32'h1, VEC);
        @(negedge clk);
        checkOutput("redir_second_exc_we", cp0_exc_we_o, 1'b0);
        checkOutput("sys_rv_T2", redirect_valid_o, 1'b1);
        nextCycle();
        clearM();
        redirect_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("sys_rv_T3", redirect_valid_o, 1'b1);
        nextCycle();
        redirect_ready_i = 1'b0;
        @(negedge clk);
        checkOutput("sys_rv_T4", redirect_valid_o, 1'b0);
        checkOutput("sys_flush_T4", flush_o, 1'b0);
        checkOutput("sys_rpc_T4", redirect_pc_o, 32'h0);

        // Drain: two accepted requests, then take
        busCycle(1'b1, 1'b0);
        busCycle(1'b1, 1'b0);
        busCycle(1'b0, 1'b0);
        applyStimulus(1'b1, 32'hc, 32'h80000020, 1'b0, 32'h0, VEC);
        sbQueue.push_back(VEC);
        @(negedge clk);
        checkOutput("drain_we_T", cp0_exc_we_o, 1'b1);
        checkOutput("drain_stall_T", stall_o, 1'b0);
        nextCycle();
        clearM();
        @(negedge clk);
        checkOutput("drain_stall", stall_o, 1'b1);
        checkOutput("drain_block", inst_req_block_o, 1'b1);
        checkOutput("drain_discard", discard_fetch_o, 1'b1);
        checkOutput("drain_rv_wait0", redirect_valid_o, 1'b0);
        busCycle(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("drain_rv_wait1", redirect_valid_o, 1'b0);
        busCycle(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("drain_rv_wait2", redirect_valid_o, 1'b0);
        checkOutput("drain_stall2", stall_o, 1'b1);
        busCycle(1'b0, 1'b0);
        redirect_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("drain_rv_rise", redirect_valid_o, 1'b1);
        checkOutput("drain_stall_off", stall_o, 1'b0);
        nextCycle();
        redirect_ready_i = 1'b0;
        @(negedge clk);
        checkOutput("drain_rv_done", redirect_valid_o, 1'b0);

        // Counter limits
        for (int j = 0; j < 3; j++) begin
            busCycle(1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("cnt_block_%0d", j), inst_req_block_o, 1'b0);
        end
        checkBlock("cnt_full", 1'b1);
        busCycle(1'b1, 1'b1);
        checkBlock("cnt_both_at_full", 1'b1);
        busCycle(1'b0, 1'b1);
        checkBlock("cnt_after_dec", 1'b0);
        busCycle(1'b1, 1'b1);
        checkBlock("cnt_both_mid", 1'b0);
        busCycle(1'b1, 1'b0);
        checkBlock("cnt_refill", 1'b1);
        repeat (5) busCycle(1'b0, 1'b1);
        busCycle(1'b1, 1'b0);
        busCycle(1'b1, 1'b0);
        checkBlock("cnt_no_underflow", 1'b0);
        busCycle(1'b1, 1'b0);
        checkBlock("cnt_full_again", 1'b1);
        repeat (3) busCycle(1'b0, 1'b1);
        checkBlock("cnt_empty", 1'b0);

        // Asynchronous reset in the middle of a drain
        busCycle(1'b1, 1'b0);
        busCycle(1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h80000040, 1'b0, 32'h0, VEC);
        nextCycle();
        @(negedge clk);
        checkOutput("rstd_in_drain", stall_o, 1'b1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("rstd_flush", flush_o, 1'b0);
        checkOutput("rstd_stall", stall_o, 1'b0);
        checkOutput("rstd_discard", discard_fetch_o, 1'b0);
        checkOutput("rstd_block", inst_req_block_o, 1'b0);
        checkOutput("rstd_rv", redirect_valid_o, 1'b0);
        checkOutput("rstd_we", cp0_exc_we_o, 1'b0);
        checkOutput("rstd_epc", cp0_epc_o, 32'h0);
        clearM();
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        checkOutput("rstd_idle_flush", flush_o, 1'b0);
        checkOutput("rstd_idle_rv", redirect_valid_o, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h8, 32'h80000050, 1'b0, 32'h0, VEC);
        sbQueue.push_back(VEC);
        @(negedge clk);
        checkOutput("rstd_take_we", cp0_exc_we_o, 1'b1);
        nextCycle();
        clearM();
        redirect_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("rstd_count_zero_rv", redirect_valid_o, 1'b1);
        checkOutput("rstd_count_zero_stall", stall_o, 1'b0);
        nextCycle();
        redirect_ready_i = 1'b0;
        @(negedge clk);
        checkOutput("rstd_rv_done", redirect_valid_o, 1'b0);

        checkOutput("sb_queue_empty", sbQueue.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
